// File: rtl/mixer_pkg.sv
// Shared types and constants for the envelope voice mixer.
// Optional build macro used by the top: MIXER_SATURATE_EN.
package mixer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ATTACK  = 2'd1,
      SUSTAIN = 2'd2,
      RELEASE = 2'd3
   } env_state_t;

   typedef logic signed [15:0] sample_t;

   localparam logic [15:0] ENV_MAX         = 16'hFFFF;
   localparam logic [15:0] OFFSET_MIDSCALE = 16'h8000;

endpackage

// File: rtl/adsr_voice.sv
// One voice's attack/sustain/release envelope, advanced only on the sample tick.
// The FSM state register r_state is the hook for external checkers.
module adsr_voice
   import mixer_pkg::*;
#(
   parameter int ATTACK_STEP  = 256,
   parameter int RELEASE_STEP = 64
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        tick,
   input  logic        gate,
   output logic [15:0] level,
   output logic        active
);

   env_state_t  r_state;
   env_state_t  w_next_state;
   logic [15:0] r_level;
   logic [15:0] w_next_level;
   logic [16:0] w_up;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state <= IDLE;
         r_level <= '0;
      end else begin
         r_state <= w_next_state;
         r_level <= w_next_level;
      end
   end

   // Gate edges change state but leave the level alone on that tick, except
   // from IDLE where the first attack step is applied immediately.
   always_comb begin
      w_next_state = r_state;
      w_next_level = r_level;
      w_up         = {1'b0, r_level} + 17'(ATTACK_STEP);
      if (tick) begin
         case (r_state)
            IDLE: begin
               w_next_level = '0;
               if (gate) begin
                  w_next_state = ATTACK;
                  w_next_level = 16'(ATTACK_STEP);
               end
            end
            ATTACK: begin
               if (!gate) begin
                  w_next_state = RELEASE;
               end else if (w_up >= {1'b0, ENV_MAX}) begin
                  w_next_state = SUSTAIN;
                  w_next_level = ENV_MAX;
               end else begin
                  w_next_level = w_up[15:0];
               end
            end
            SUSTAIN: begin
               w_next_level = ENV_MAX;
               if (!gate) w_next_state = RELEASE;
            end
            RELEASE: begin
               if (gate) begin
                  w_next_state = ATTACK;
               end else if (r_level <= 16'(RELEASE_STEP)) begin
                  w_next_state = IDLE;
                  w_next_level = '0;
               end else begin
                  w_next_level = r_level - 16'(RELEASE_STEP);
               end
            end
            default: begin
               w_next_state = IDLE;
               w_next_level = '0;
            end
         endcase
      end
   end

   assign level  = r_level;
   assign active = (r_state != IDLE);

endmodule

// File: rtl/envelope_voice_mixer.sv
// Envelope-scaled voice mixer feeding the PDM driver with offset-binary words.
// Build macro MIXER_SATURATE_EN clamps the shifted sum instead of wrapping it.
module envelope_voice_mixer
   import mixer_pkg::*;
#(
   parameter int NUM_VOICES   = 8,
   parameter int ATTACK_STEP  = 256,
   parameter int RELEASE_STEP = 64,
   parameter int MIX_SHIFT    = 3
) (
   input  logic                                clk_in,
   input  logic                                rst_in,
   input  logic                                sample_tick,
   input  logic [NUM_VOICES-1:0]               gate_in,
   input  sample_t                             sample_in [NUM_VOICES],
   output logic [15:0]                         mix_out,
   output logic                                mix_valid,
   output logic                                busy_out,
   output logic                                overrun_out,
   output logic [$clog2(NUM_VOICES+1)-1:0]     active_voices_out
);

   localparam int AW = 16 + $clog2(NUM_VOICES);
   localparam int CW = $clog2(NUM_VOICES + 1);
   localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

   logic [15:0]           w_level  [NUM_VOICES];
   logic [NUM_VOICES-1:0] w_active;
   logic [CW-1:0]         w_active_cnt;

   logic [15:0]           r_snap_level  [NUM_VOICES];
   sample_t               r_snap_sample [NUM_VOICES];
   logic                  r_busy;
   logic [CW-1:0]         r_cnt;
   sample_t               r_prod;
   logic signed [AW-1:0]  r_acc;
   logic [15:0]           r_mix;
   logic                  r_valid;
   logic                  r_overrun;
   logic [CW-1:0]         r_active;

   logic [IW-1:0]         w_idx;
   logic signed [32:0]    w_prod_full;
   sample_t               w_prod;
   logic signed [AW-1:0]  w_sum;
   logic signed [AW-1:0]  w_shift;
   logic [15:0]           w_clip;

   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
      adsr_voice #(
         .ATTACK_STEP  (ATTACK_STEP),
         .RELEASE_STEP (RELEASE_STEP)
      ) u_voice (
         .clk_in (clk_in),
         .rst_in (rst_in),
         .tick   (sample_tick),
         .gate   (gate_in[g]),
         .level  (w_level[g]),
         .active (w_active[g])
      );
   end

   always_comb begin
      w_active_cnt = '0;
      for (int i = 0; i < NUM_VOICES; i++) w_active_cnt = w_active_cnt + CW'(w_active[i]);
   end

   // Unsigned level is zero-extended so the signed multiply keeps full range.
   assign w_idx       = r_cnt[IW-1:0];
   assign w_prod_full = r_snap_sample[w_idx] * $signed({1'b0, r_snap_level[w_idx]});
   assign w_prod      = 16'(w_prod_full >>> 16);
   assign w_sum       = r_acc + AW'(r_prod);
   assign w_shift     = w_sum >>> MIX_SHIFT;

`ifdef MIXER_SATURATE_EN
   always_comb begin
      if (w_shift > AW'(32767))       w_clip = 16'h7FFF;
      else if (w_shift < AW'(-32768)) w_clip = 16'h8000;
      else                            w_clip = 16'(w_shift);
   end
`else
   assign w_clip = 16'(w_shift);
`endif

   // r_cnt walks 0..NUM_VOICES: multiply voice r_cnt, accumulate the previous
   // product, and on the last step fold the final product straight into the output.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_busy    <= 1'b0;
         r_cnt     <= '0;
         r_prod    <= '0;
         r_acc     <= '0;
         r_mix     <= OFFSET_MIDSCALE;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
         r_active  <= '0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            r_snap_level[i]  <= '0;
            r_snap_sample[i] <= '0;
         end
      end else begin
         r_valid  <= 1'b0;
         r_active <= w_active_cnt;
         if (sample_tick) begin
            if (r_busy) begin
               r_overrun <= 1'b1;
            end else begin
               r_busy <= 1'b1;
               r_cnt  <= '0;
               r_acc  <= '0;
               for (int i = 0; i < NUM_VOICES; i++) begin
                  r_snap_level[i]  <= w_level[i];
                  r_snap_sample[i] <= sample_in[i];
               end
            end
         end
         if (r_busy) begin
            r_prod <= w_prod;
            r_cnt  <= r_cnt + 1'b1;
            if (r_cnt != '0) r_acc <= w_sum;
            if (r_cnt == CW'(NUM_VOICES)) begin
               r_mix   <= w_clip ^ OFFSET_MIDSCALE;
               r_valid <= 1'b1;
               r_busy  <= 1'b0;
            end
         end
      end
   end

   assign mix_out           = r_mix;
   assign mix_valid         = r_valid;
   assign busy_out          = r_busy;
   assign overrun_out       = r_overrun;
   assign active_voices_out = r_active;

endmodule

// File: tb/tb_envelope_voice_mixer.sv
// Directed bench for envelope_voice_mixer: default instance plus a MIX_SHIFT=0 instance.
module tb_envelope_voice_mixer;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              tick = 1'b0;
   logic [7:0]        gate = '0;
   logic [7:0]        gate0 = '0;
   logic signed [15:0] smp  [8];
   logic signed [15:0] smp0 [8];

   logic [15:0] mix, mix0;
   logic        mv, mv0, busy, busy0, ovr, ovr0;
   logic [3:0]  act, act0;

   int total = 0;
   int bad = 0;
   int lat;
   logic [15:0] m, m0;

   envelope_voice_mixer u_dut (
      .clk_in(clk), .rst_in(rst), .sample_tick(tick), .gate_in(gate), .sample_in(smp),
      .mix_out(mix), .mix_valid(mv), .busy_out(busy), .overrun_out(ovr),
      .active_voices_out(act)
   );

   envelope_voice_mixer #(.MIX_SHIFT(0)) u_dut0 (
      .clk_in(clk), .rst_in(rst), .sample_tick(tick), .gate_in(gate0), .sample_in(smp0),
      .mix_out(mix0), .mix_valid(mv0), .busy_out(busy0), .overrun_out(ovr0),
      .active_voices_out(act0)
   );

   always #5 clk = ~clk;

   // One tick; lat is the cycle offset of mix_valid from the tick cycle.
   task automatic do_tick(output int l, output logic [15:0] a, output logic [15:0] b);
      @(posedge clk); #1 tick = 1'b1;
      @(posedge clk); #1 tick = 1'b0;
      l = 1;
      while (mv !== 1'b1 && l < 30) begin
         @(posedge clk); #1;
         l++;
      end
      if (mv !== 1'b1) begin
         total++; bad++;
         $display("FAIL tick_timeout: mix_valid not seen within %0d cycles", l);
         l = -1;
      end
      a = mix;
      b = mix0;
      repeat (2) @(posedge clk);
   endtask

   task automatic run_ticks(input int n);
      int l;
      logic [15:0] a, b;
      repeat (n) do_tick(l, a, b);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++; if (mix !== 16'h8000) begin bad++; $display("FAIL reset_mix: got %h want 8000", mix); end
      total++; if (mv !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", mv); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (ovr !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", ovr); end
      total++; if (act !== 4'd0) begin bad++; $display("FAIL reset_active: got %0d want 0", act); end
      @(negedge clk) rst = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_attack_sustain();
      gate = 8'h01;
      smp[0] = 16'h4000;
      run_ticks(255);
      do_tick(lat, m, m0);
      total++; if (m !== 16'h87F8) begin bad++; $display("FAIL attack_255: got %h want 87f8", m); end
      total++; if (act !== 4'd1) begin bad++; $display("FAIL attack_active: got %0d want 1", act); end
      do_tick(lat, m, m0);
      total++; if (m !== 16'h87FF) begin bad++; $display("FAIL sustain_mix: got %h want 87ff", m); end
      total++; if (lat !== 10) begin bad++; $display("FAIL valid_latency: got %0d want 10", lat); end
   endtask

   task automatic test_release();
      gate = 8'h00;
      do_tick(lat, m, m0);
      total++; if (m !== 16'h87FF) begin bad++; $display("FAIL release_first: got %h want 87ff", m); end
      run_ticks(1023);
      total++; if (act !== 4'd1) begin bad++; $display("FAIL release_active: got %0d want 1", act); end
      do_tick(lat, m, m0);
      total++; if (m !== 16'h8001) begin bad++; $display("FAIL release_last: got %h want 8001", m); end
      total++; if (act !== 4'd0) begin bad++; $display("FAIL release_idle: got %0d want 0", act); end
      do_tick(lat, m, m0);
      total++; if (m !== 16'h8000) begin bad++; $display("FAIL idle_mix: got %h want 8000", m); end
   endtask

   task automatic test_reraise();
      gate = 8'h01;
      run_ticks(256);
      gate = 8'h00;
      run_ticks(101);
      gate = 8'h01;
      do_tick(lat, m, m0);
      total++; if (m !== 16'h8737) begin bad++; $display("FAIL reraise_level: got %h want 8737", m); end
      run_ticks(24);
      do_tick(lat, m, m0);
      total++; if (m !== 16'h87F7) begin bad++; $display("FAIL reraise_25: got %h want 87f7", m); end
      do_tick(lat, m, m0);
      total++; if (m !== 16'h87FF) begin bad++; $display("FAIL reraise_sustain: got %h want 87ff", m); end
      total++; if (act !== 4'd1) begin bad++; $display("FAIL reraise_active: got %0d want 1", act); end
   endtask

   task automatic test_reset_mid_mac();
      int pulses = 0;
      @(posedge clk); #1 tick = 1'b1;
      @(posedge clk); #1 tick = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %b want 1", busy); end
      rst = 1'b1;
      #1;
      total++; if (mix !== 16'h8000) begin bad++; $display("FAIL mid_reset_mix: got %h want 8000", mix); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
      total++; if (act !== 4'd0) begin bad++; $display("FAIL mid_reset_active: got %0d want 0", act); end
      @(posedge clk); #1 rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (mv === 1'b1) pulses++;
         @(posedge clk); #1;
      end
      total++; if (pulses !== 0) begin bad++; $display("FAIL mid_reset_valid: got %0d pulses want 0", pulses); end
      do_tick(lat, m, m0);
      total++; if (m !== 16'h8000) begin bad++; $display("FAIL mid_reset_level: got %h want 8000", m); end
      total++; if (ovr !== 1'b0) begin bad++; $display("FAIL mid_reset_overrun: got %b want 0", ovr); end
   endtask

   task automatic test_mixed_sign();
      gate = 8'h03;
      smp[0] = 16'h4000;
      smp[1] = 16'hC000;
      run_ticks(256);
      do_tick(lat, m, m0);
      total++; if (m !== 16'h7FFF) begin bad++; $display("FAIL mixed_sign: got %h want 7fff", m); end
   endtask

   task automatic test_all_voices();
      logic [15:0] exp_pos0, exp_neg0;
`ifdef MIXER_SATURATE_EN
      exp_pos0 = 16'hFFFF;
      exp_neg0 = 16'h0000;
`else
      exp_pos0 = 16'h7FF0;
      exp_neg0 = 16'h8000;
`endif
      gate = 8'hFF;
      gate0 = 8'hFF;
      for (int i = 0; i < 8; i++) begin
         smp[i] = 16'h7FFF;
         smp0[i] = 16'h7FFF;
      end
      run_ticks(256);
      do_tick(lat, m, m0);
      total++; if (m !== 16'hFFFE) begin bad++; $display("FAIL all_pos_shift3: got %h want fffe", m); end
      total++; if (m0 !== exp_pos0) begin bad++; $display("FAIL all_pos_shift0: got %h want %h", m0, exp_pos0); end
      total++; if (act !== 4'd8) begin bad++; $display("FAIL all_active: got %0d want 8", act); end
      for (int i = 0; i < 8; i++) begin
         smp[i] = 16'h8000;
         smp0[i] = 16'h8000;
      end
      do_tick(lat, m, m0);
      total++; if (m !== 16'h0000) begin bad++; $display("FAIL all_neg_shift3: got %h want 0000", m); end
      total++; if (m0 !== exp_neg0) begin bad++; $display("FAIL all_neg_shift0: got %h want %h", m0, exp_neg0); end
   endtask

   task automatic test_overrun();
      int pulses = 0;
      total++; if (ovr !== 1'b0) begin bad++; $display("FAIL overrun_pre: got %b want 0", ovr); end
      @(posedge clk); #1 tick = 1'b1;
      @(posedge clk); #1 tick = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1 tick = 1'b1;
      @(posedge clk); #1 tick = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (mv === 1'b1) pulses++;
         @(posedge clk); #1;
      end
      total++; if (pulses !== 1) begin bad++; $display("FAIL overrun_valid_count: got %0d want 1", pulses); end
      total++; if (ovr !== 1'b1) begin bad++; $display("FAIL overrun_set: got %b want 1", ovr); end
      run_ticks(10);
      total++; if (ovr !== 1'b1) begin bad++; $display("FAIL overrun_sticky: got %b want 1", ovr); end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         smp[i] = '0;
         smp0[i] = '0;
      end
      test_reset();
      test_attack_sustain();
      test_release();
      test_reraise();
      test_reset_mid_mac();
      test_mixed_sign();
      test_all_voices();
      test_overrun();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/envelope_voice_mixer.md
Name: envelope_voice_mixer

Overview:
- Stage between the per-note sample BRAMs and the PDM speaker driver.
- Runs a per-voice attack/sustain/release envelope from the touch-gate bits.
- On each sample tick, scales every voice's signed sample by its envelope and sums the voices through one time-multiplexed multiplier.
- Emits one offset-binary 16-bit word per tick for `pdm.dc_in`.

Parameters:
- NUM_VOICES, 8, number of voices/gate bits.
- ATTACK_STEP, 256, envelope increment per tick in ATTACK.
- RELEASE_STEP, 64, envelope decrement per tick in RELEASE.
- MIX_SHIFT, 3, arithmetic right shift applied to the voice sum before output.

Ports:
- clk_in, input, 1: 100 MHz system clock.
- rst_in, input, 1: asynchronous, active-high reset.
- sample_tick, input, 1: one-cycle pulse at the sample rate (16384 Hz).
- gate_in, input, NUM_VOICES: per-voice gate from the note decoder.
- sample_in, input, NUM_VOICES x 16 (unpacked array): signed two's-complement BRAM samples, stable from tick to tick.
- mix_out, output, 16: unsigned offset-binary mix, held between updates.
- mix_valid, output, 1: one-cycle pulse when mix_out updates.
- busy_out, output, 1: MAC sequence in progress.
- overrun_out, output, 1: sticky; a tick arrived while busy.
- active_voices_out, output, $clog2(NUM_VOICES+1): count of voices not in IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - all envelopes 0, all voices IDLE
  - mix_out=16'h8000, mix_valid=0, busy_out=0, overrun_out=0, active_voices_out=0
  - reset mid-sequence aborts the MAC; no mix_valid is produced.
- Per-voice FSM, evaluated only on sample_tick, with gate sampled on that cycle:
  - IDLE: gate=1 -> ATTACK.
  - ATTACK: level += ATTACK_STEP, saturating at 65535; reaching 65535 -> SUSTAIN; gate=0 -> RELEASE, level unchanged that tick.
  - SUSTAIN: level held at 65535; gate=0 -> RELEASE.
  - RELEASE: level -= RELEASE_STEP, floored at 0; reaching 0 -> IDLE; gate=1 -> ATTACK from the current level (no reset to 0).
  - IDLE forces level=0.
- MAC sequence:
  - Tick at cycle T with busy_out=0: snapshot the pre-update envelopes and all sample_in words; busy_out=1 from T+1.
  - Cycles T+1..T+NUM_VOICES: voice i product = (signed sample x unsigned level) >>> 16, yielding signed 16 bits. Products are registered, then accumulated in a signed accumulator of 16+$clog2(NUM_VOICES) bits.
  - Cycle T+NUM_VOICES+2: sum >>> MIX_SHIFT, reduced to signed 16 bits (see Optional Feature), MSB inverted to offset binary.
  - On that cycle: mix_out updates, mix_valid=1, busy_out returns to 0.
- Tick while busy_out=1:
  - envelopes still update
  - no new MAC starts
  - overrun_out set; it stays set until reset.
- Envelope updates never stall on the MAC; a voice in IDLE contributes 0.
- active_voices_out is registered and reflects the FSM state after each tick.

Optional Feature:
- Macro: MIXER_SATURATE_EN.
- Defined: the shifted sum is clamped to [-32768, 32767] before the offset conversion.
- Undefined: the low 16 bits are taken (two's-complement wrap); this saves the comparator logic.

Decomposition:
- Package mixer_pkg holds:
  - typedef env_state_t enum {IDLE, ATTACK, SUSTAIN, RELEASE}
  - typedef sample_t logic signed [15:0]
  - localparam ENV_MAX=16'hFFFF, OFFSET_MIDSCALE=16'h8000
- Sub-module adsr_voice, one instance per voice via generate:
  - FSM plus level register
  - inputs: clk_in, rst_in, tick, gate
  - outputs: level, active
- The top module holds the snapshot, the shared multiplier, the accumulator and the output formatting.

Test Plan:
- Reset asserted mid-MAC (cycle T+3) -> mix_out=16'h8000, no mix_valid, busy_out=0, all levels 0.
- gate_in=8'h01, sample_in[0]=16'h4000, 256 ticks spaced 6104 cycles -> env0=65535 in SUSTAIN; next mix_out=16'h87FF (0x3FFF>>>3=0x07FF); mix_valid exactly NUM_VOICES+2 cycles after the tick.
- Drop gate_in[0] from SUSTAIN -> 1024 ticks later voice IDLE, active_voices_out=0, mix_out=16'h8000.
- Re-raise the gate after 100 release ticks (level 59135) -> ATTACK from 59135, SUSTAIN after 26 ticks.
- MIX_SHIFT=0, all 8 voices SUSTAIN, all samples 16'h7FFF -> with MIXER_SATURATE_EN mix_out=16'hFFFF; without it mix_out=16'h7FF0.
- Two ticks 3 cycles apart -> one mix_valid only, overrun_out=1 and still 1 after 10 further clean ticks.
